// File: rtl/dmg_oam_dma.sv
`default_nettype none
// ============================================================================
// Module   : dmg_oam_dma
// Purpose  : FF46 OAM DMA engine. A CPU write to FF46 starts a one M-cycle
//            setup, then copies 160 bytes from {page,00..9F} into OAM (one
//            byte per M-cycle). Pages E0..FF are folded onto C0..DF (echo
//            WRAM). The CPU loses the non-HRAM bus while dma_active is high.
// Options  : OAM_DMA_READBACK_EN - when defined, FF46 reads return the last
//            written page; otherwise FF46 reads return 8'hFF.
// Revision : 1.0 - initial release
// ============================================================================
module dmg_oam_dma (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        reg_write,
    input  logic [7:0]  reg_d_wr,
    output logic [7:0]  reg_d_rd,
    output logic        dma_active,
    output logic        cpu_bus_grant,
    output logic [15:0] dma_src_addr,
    input  logic [7:0]  dma_d_in,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_d_wr,
    output logic        oam_write
);

    localparam logic [7:0] C_LAST_INDEX  = 8'd159;
    localparam logic [7:0] C_ECHO_BASE   = 8'hE0;
    localparam logic [7:0] C_ECHO_OFFSET = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_page;
    logic [7:0] w_page_next;
    logic [7:0] r_index;
    logic [7:0] w_index_next;
    logic       r_oam_write;
    logic       w_oam_write_next;
    logic [7:0] r_oam_addr;
    logic [7:0] w_oam_addr_next;
    logic [7:0] r_oam_d_wr;
    logic [7:0] w_oam_d_wr_next;
    logic [7:0] w_src_page;

    // State register; reset wins over everything, all advances wait for ce.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_page      <= 8'h00;
            r_index     <= 8'h00;
            r_oam_write <= 1'b0;
            r_oam_addr  <= 8'h00;
            r_oam_d_wr  <= 8'h00;
        end else begin
            r_state     <= w_state_next;
            r_page      <= w_page_next;
            r_index     <= w_index_next;
            r_oam_write <= w_oam_write_next;
            r_oam_addr  <= w_oam_addr_next;
            r_oam_d_wr  <= w_oam_d_wr_next;
        end
    end

    // Next-state logic: an FF46 write always (re)starts the setup M-cycle;
    // in XFER each ce captures the current byte, which is written to OAM
    // during the following M-cycle even if a restart or the end follows.
    always_comb begin
        w_state_next     = r_state;
        w_page_next      = r_page;
        w_index_next     = r_index;
        w_oam_write_next = r_oam_write;
        w_oam_addr_next  = r_oam_addr;
        w_oam_d_wr_next  = r_oam_d_wr;
        if (ce) begin
            w_oam_write_next = 1'b0;
            if (reg_write) begin
                w_state_next = ST_START;
                w_page_next  = reg_d_wr;
                w_index_next = 8'h00;
            end else begin
                case (r_state)
                    ST_START: begin
                        w_state_next = ST_XFER;
                    end
                    ST_XFER: begin
                        w_oam_write_next = 1'b1;
                        w_oam_addr_next  = r_index;
                        w_oam_d_wr_next  = dma_d_in;
                        if (r_index == C_LAST_INDEX) begin
                            w_state_next = ST_IDLE;
                            w_index_next = 8'h00;
                        end else begin
                            w_index_next = r_index + 8'd1;
                        end
                    end
                    default: begin
                        w_state_next = r_state;
                    end
                endcase
            end
        end
    end

    // Echo WRAM pages fold down onto the real WRAM pages.
    always_comb begin
        w_src_page = r_page;
        if (r_page >= C_ECHO_BASE) begin
            w_src_page = r_page - C_ECHO_OFFSET;
        end
    end

    // Bus address is only driven while a read is in progress.
    always_comb begin
        dma_src_addr = 16'h0000;
        if (r_state == ST_XFER) begin
            dma_src_addr = {w_src_page, r_index};
        end
    end

    // Busy covers setup, reads and the trailing OAM write M-cycle.
    assign dma_active    = (r_state != ST_IDLE) || r_oam_write;
    assign cpu_bus_grant = ~dma_active;
    assign oam_write     = r_oam_write;
    assign oam_addr      = r_oam_addr;
    assign oam_d_wr      = r_oam_d_wr;

`ifdef OAM_DMA_READBACK_EN
    assign reg_d_rd = r_page;
`else
    assign reg_d_rd = 8'hFF;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmg_oam_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmg_oam_dma
// Purpose  : Self-checking bench for dmg_oam_dma. Expected behaviour comes
//            from a per-M-cycle schedule computed from the list of FF46
//            writes (setup, read and OAM-write cycles of each transfer).
// Options  : OAM_DMA_READBACK_EN selects the expected FF46 readback value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmg_oam_dma;

    localparam int MAXM = 700;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        reg_write;
    logic [7:0]  reg_d_wr;
    logic [7:0]  reg_d_rd;
    logic        dma_active;
    logic        cpu_bus_grant;
    logic [15:0] dma_src_addr;
    logic [7:0]  dma_d_in;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_d_wr;
    logic        oam_write;

    logic [7:0]  bus_salt;
    logic [7:0]  last_page;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Stimulus schedule (indexed by M-cycle) and the resulting expectations.
    bit          wr_at [MAXM];
    logic [7:0]  d_at [MAXM];
    bit          exp_active [MAXM];
    bit          exp_write [MAXM];
    logic [7:0]  exp_addr [MAXM];
    logic [7:0]  exp_data [MAXM];
    logic [15:0] exp_src [MAXM];
    bit          obs_active [MAXM];
    bit          obs_write [MAXM];
    logic [7:0]  obs_addr [MAXM];
    logic [7:0]  obs_data [MAXM];
    logic [15:0] obs_src [MAXM];

    always #5 clk = ~clk;

    // Memory model: every address holds a byte derived from the address.
    assign dma_d_in = dma_src_addr[7:0] ^ 8'h5A ^ (dma_src_addr[15:8] & bus_salt);

    function automatic logic [7:0] bus_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] & bus_salt);
    endfunction

    function automatic logic [7:0] exp_rd();
`ifdef OAM_DMA_READBACK_EN
        return last_page;
`else
        return 8'hFF;
`endif
    endfunction

    dmg_oam_dma dut (
        .clk           (clk),
        .rst           (rst),
        .ce            (ce),
        .reg_write     (reg_write),
        .reg_d_wr      (reg_d_wr),
        .reg_d_rd      (reg_d_rd),
        .dma_active    (dma_active),
        .cpu_bus_grant (cpu_bus_grant),
        .dma_src_addr  (dma_src_addr),
        .dma_d_in      (dma_d_in),
        .oam_addr      (oam_addr),
        .oam_d_wr      (oam_d_wr),
        .oam_write     (oam_write)
    );

    // One M-cycle of 4 clocks; ce on the last. A CPU write holds reg_write
    // for the whole M-cycle; with noise, stray strobes appear on non-ce clocks.
    task automatic mcycle(input bit wr, input logic [7:0] d, input bit noise);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ce        = (i == 3);
            reg_d_wr  = wr ? d : 8'($urandom);
            reg_write = wr ? 1'b1 : (noise && (i != 3) && ($urandom_range(0, 1) == 1));
        end
        @(posedge clk);
        #1;
        ce        = 1'b0;
        reg_write = 1'b0;
    endtask

    task automatic clear_schedule();
        for (int m = 0; m < MAXM; m++) begin
            wr_at[m] = 1'b0;
            d_at[m]  = 8'h00;
        end
    endtask

    // Expected timeline: write in M t, setup in t+1, reads t+2..t+161 (cut at
    // the next write, whose own M-cycle still reads but does not capture),
    // each captured byte written to OAM in the M-cycle after its read.
    task automatic build_model(input int n_cyc);
        int         t_list[$];
        logic [7:0] p_list[$];
        for (int m = 0; m < MAXM; m++) begin
            exp_active[m] = 1'b0;
            exp_write[m]  = 1'b0;
            exp_addr[m]   = 8'h00;
            exp_data[m]   = 8'h00;
            exp_src[m]    = 16'h0000;
        end
        for (int m = 0; m < n_cyc; m++) begin
            if (wr_at[m]) begin
                t_list.push_back(m);
                p_list.push_back(d_at[m]);
            end
        end
        for (int k = 0; k < t_list.size(); k++) begin
            int         t;
            int         t_next;
            int         r;
            logic [7:0] sp;
            t      = t_list[k];
            t_next = (k + 1 < t_list.size()) ? t_list[k + 1] : 1 << 30;
            sp     = (p_list[k] >= 8'hE0) ? p_list[k] - 8'h20 : p_list[k];
            exp_active[t + 1] = 1'b1;
            for (int n = 0; n < 160; n++) begin
                r = t + 2 + n;
                if (r > t_next) break;
                exp_src[r]    = {sp, 8'(n)};
                exp_active[r] = 1'b1;
                if (r < t_next) begin
                    exp_active[r + 1] = 1'b1;
                    exp_write[r + 1]  = 1'b1;
                    exp_addr[r + 1]   = 8'(n);
                    exp_data[r + 1]   = bus_byte({sp, 8'(n)});
                end
            end
        end
    endtask

    // Drives the schedule from an idle DUT and compares every M-cycle.
    task automatic run_schedule(input int n_cyc, input bit noise);
        int mo;
        build_model(n_cyc);
        for (int m = 0; m < n_cyc; m++) begin
            mcycle(wr_at[m], d_at[m], noise);
            if (wr_at[m]) last_page = d_at[m];
            mo = m + 1;
            obs_active[mo] = dma_active;
            obs_write[mo]  = oam_write;
            obs_addr[mo]   = oam_addr;
            obs_data[mo]   = oam_d_wr;
            obs_src[mo]    = dma_src_addr;
            n_checks++;
            if (dma_active !== exp_active[mo]) begin
                n_fail++;
                $display("FAIL dma_active M%0d: got %b expected %b", mo, dma_active, exp_active[mo]);
            end
            n_checks++;
            if (cpu_bus_grant !== !exp_active[mo]) begin
                n_fail++;
                $display("FAIL cpu_bus_grant M%0d: got %b expected %b", mo, cpu_bus_grant, !exp_active[mo]);
            end
            n_checks++;
            if (oam_write !== exp_write[mo]) begin
                n_fail++;
                $display("FAIL oam_write M%0d: got %b expected %b", mo, oam_write, exp_write[mo]);
            end
            n_checks++;
            if (dma_src_addr !== exp_src[mo]) begin
                n_fail++;
                $display("FAIL dma_src_addr M%0d: got %h expected %h", mo, dma_src_addr, exp_src[mo]);
            end
            if (exp_write[mo]) begin
                n_checks++;
                if (oam_addr !== exp_addr[mo] || oam_d_wr !== exp_data[mo]) begin
                    n_fail++;
                    $display("FAIL oam_addr/data M%0d: got %h/%h expected %h/%h",
                             mo, oam_addr, oam_d_wr, exp_addr[mo], exp_data[mo]);
                end
            end
            n_checks++;
            if (reg_d_rd !== exp_rd()) begin
                n_fail++;
                $display("FAIL reg_d_rd M%0d: got %h expected %h", mo, reg_d_rd, exp_rd());
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        ce        = 1'b0;
        reg_write = 1'b0;
        reg_d_wr  = 8'h00;
        repeat (3) @(negedge clk);
        // reset must dominate a simultaneous ce + FF46 write
        ce        = 1'b1;
        reg_write = 1'b1;
        reg_d_wr  = 8'h77;
        @(posedge clk);
        #1;
        last_page = 8'h00;
        n_checks++;
        if (dma_active !== 1'b0 || cpu_bus_grant !== 1'b1 || oam_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset ctrl: got active=%b grant=%b wr=%b expected 0/1/0", dma_active, cpu_bus_grant, oam_write);
        end
        n_checks++;
        if (dma_src_addr !== 16'h0000 || oam_addr !== 8'h00 || oam_d_wr !== 8'h00) begin
            n_fail++;
            $display("FAIL reset data: got src=%h addr=%h data=%h expected 0000/00/00", dma_src_addr, oam_addr, oam_d_wr);
        end
        n_checks++;
        if (reg_d_rd !== exp_rd()) begin
            n_fail++;
            $display("FAIL reset reg_d_rd: got %h expected %h", reg_d_rd, exp_rd());
        end
        @(negedge clk);
        ce        = 1'b0;
        reg_write = 1'b0;
        rst       = 1'b1;
    endtask

    task automatic test_basic_transfer();
        int first_wr;
        int fall;
        int cnt;
        bus_salt = 8'h00;
        clear_schedule();
        wr_at[0] = 1'b1;
        d_at[0]  = 8'hC0;
        run_schedule(170, 1'b0);
        first_wr = -1;
        fall     = -1;
        cnt      = 0;
        for (int m = 1; m <= 170; m++) begin
            if (obs_write[m]) cnt++;
            if (obs_write[m] && first_wr < 0) first_wr = m;
            if (!obs_active[m] && fall < 0) fall = m;
        end
        n_checks++;
        if (first_wr !== 3) begin
            n_fail++;
            $display("FAIL basic first oam_write: got M%0d expected M3", first_wr);
        end
        n_checks++;
        if (fall !== 163) begin
            n_fail++;
            $display("FAIL basic dma_active fall: got M%0d expected M163", fall);
        end
        n_checks++;
        if (cnt !== 160) begin
            n_fail++;
            $display("FAIL basic write count: got %0d expected 160", cnt);
        end
        n_checks++;
        if (obs_addr[162] !== 8'd159 || obs_data[162] !== (8'd159 ^ 8'h5A)) begin
            n_fail++;
            $display("FAIL basic last byte: got %h/%h expected 9f/%h", obs_addr[162], obs_data[162], 8'd159 ^ 8'h5A);
        end
    endtask

    task automatic test_echo();
        bus_salt = 8'hFF;
        clear_schedule();
        wr_at[0] = 1'b1;
        d_at[0]  = 8'hE1;
        run_schedule(170, 1'b0);
        n_checks++;
        if (obs_src[2] !== 16'hC100 || obs_src[161] !== 16'hC19F || obs_src[162] !== 16'h0000) begin
            n_fail++;
            $display("FAIL echo src range: got %h..%h,%h expected c100..c19f,0000", obs_src[2], obs_src[161], obs_src[162]);
        end
    endtask

    task automatic test_restart();
        int span;
        bus_salt = 8'h00;
        clear_schedule();
        wr_at[0]  = 1'b1;
        d_at[0]   = 8'hC0;
        wr_at[52] = 1'b1;   // 50th capture happened at the end of M51
        d_at[52]  = 8'h80;
        run_schedule(222, 1'b0);
        span = 0;
        for (int m = 1; m <= 222; m++) if (obs_active[m]) span++;
        n_checks++;
        if (obs_write[52] !== 1'b1 || obs_addr[52] !== 8'd49) begin
            n_fail++;
            $display("FAIL restart pending byte: got wr=%b addr=%0d expected 1/49", obs_write[52], obs_addr[52]);
        end
        n_checks++;
        if (obs_write[53] !== 1'b0 || obs_src[53] !== 16'h0000 || obs_src[54] !== 16'h8000) begin
            n_fail++;
            $display("FAIL restart setup: got wr=%b src=%h,%h expected 0/0000,8000", obs_write[53], obs_src[53], obs_src[54]);
        end
        n_checks++;
        if (obs_write[55] !== 1'b1 || obs_addr[55] !== 8'd0) begin
            n_fail++;
            $display("FAIL restart index: got wr=%b addr=%0d expected 1/0", obs_write[55], obs_addr[55]);
        end
        // setup + 51 XFER M-cycles before the restart, then setup + 160 reads + last write
        n_checks++;
        if (span !== 52 + 1 + 161) begin
            n_fail++;
            $display("FAIL restart active span: got %0d expected %0d", span, 52 + 1 + 161);
        end
    endtask

    task automatic test_reset_mid();
        bus_salt = 8'h00;
        mcycle(1'b1, 8'hC0, 1'b0);
        for (int m = 1; m < 12; m++) mcycle(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (dma_src_addr !== 16'hC00A) begin
            n_fail++;
            $display("FAIL reset_mid index10 src: got %h expected c00a", dma_src_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        last_page = 8'h00;
        n_checks++;
        if (oam_write !== 1'b0 || dma_active !== 1'b0 || cpu_bus_grant !== 1'b1 || dma_src_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid abort: got wr=%b active=%b grant=%b src=%h expected 0/0/1/0000",
                     oam_write, dma_active, cpu_bus_grant, dma_src_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int m = 0; m < 3; m++) begin
            mcycle(1'b0, 8'h00, 1'b0);
            n_checks++;
            if (oam_write !== 1'b0 || dma_active !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid trailing: got wr=%b active=%b expected 0/0", oam_write, dma_active);
            end
        end
        clear_schedule();
        wr_at[0] = 1'b1;
        d_at[0]  = 8'hD0;
        run_schedule(170, 1'b0);
    endtask

    task automatic test_ce_gating();
        int cnt;
        bus_salt = 8'h3C;
        clear_schedule();
        wr_at[2] = 1'b1;
        d_at[2]  = 8'h12;
        run_schedule(175, 1'b1);
        cnt = 0;
        for (int m = 1; m <= 175; m++) if (obs_write[m]) cnt++;
        n_checks++;
        if (cnt !== 160) begin
            n_fail++;
            $display("FAIL ce_gating write count: got %0d expected 160", cnt);
        end
    endtask

    task automatic test_readback();
        logic [7:0] want;
`ifdef OAM_DMA_READBACK_EN
        want = 8'h9A;
`else
        want = 8'hFF;
`endif
        bus_salt = 8'h00;
        clear_schedule();
        wr_at[0] = 1'b1;
        d_at[0]  = 8'h9A;
        run_schedule(166, 1'b0);
        n_checks++;
        if (reg_d_rd !== want) begin
            n_fail++;
            $display("FAIL readback: got %h expected %h", reg_d_rd, want);
        end
    endtask

    task automatic test_random();
        int t1;
        int t2;
        for (int it = 0; it < 4; it++) begin
            bus_salt = 8'($urandom);
            clear_schedule();
            t1 = $urandom_range(0, 5);
            t2 = t1 + (($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 200));
            wr_at[t1] = 1'b1;
            d_at[t1]  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(224, 255)) : 8'($urandom);
            wr_at[t2] = 1'b1;
            d_at[t2]  = 8'($urandom);
            run_schedule(t2 + 170, 1'b1);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_salt  = 8'h00;
        last_page = 8'h00;
        test_reset();
        test_basic_transfer();
        test_echo();
        test_restart();
        test_reset_mid();
        test_ce_gating();
        test_readback();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
